mmio_button_port: RTL and testbench

- Memory-mapped input peripheral for the four board push-buttons (BTNU, BTNL, BTND, BTNR).
- Synchronizes and debounces each button, then latches press events in sticky bits.
- The processor reads status with a load from STAT_ADDR and clears events with a store to CLR_ADDR (write-1-to-clear).
- Sits beside the existing switch-read and LED-write decode in the top level, on the processor clock.

---
 rtl/mmio_button_port.sv | 133 +++++++++++++
 tb/tb_mmio_button_port.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_button_port.sv
// mmio_button_port: memory-mapped push-button input port.
// Each button is synchronized, debounced, and its presses are latched as sticky
// events with an overflow flag for presses that land on an unread event.
// Status is read at STAT_ADDR; a store to CLR_ADDR clears events (wdata[3:0])
// and overflow flags (wdata[11:8]) where the written bit is 1.
// Optional auto-repeat while a button is held: define BTN_REPEAT_EN.
module mmio_button_port #(
  parameter int          DEBOUNCE_CYCLES = 400000,
  parameter int          CNT_W           = 20,
  parameter logic [31:0] STAT_ADDR       = 32'd4098,
  parameter logic [31:0] CLR_ADDR        = 32'd4099
`ifdef BTN_REPEAT_EN
  ,
  parameter int          REPEAT_DELAY    = 20000000,
  parameter int          REPEAT_PERIOD   = 8000000
`endif
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic [3:0]  btn_i,
  input  logic [31:0] mem_addr_i,
  input  logic        mem_wren_i,
  input  logic [31:0] mem_wdata_i,
  output logic        hit_o,
  output logic [31:0] rdata_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       ev_q, ev_d, ovf_q, ovf_d;
  logic [3:0]       rise, inject, evt, clr_ev, clr_ovf;
  logic             clr_hit;
  logic             unused_wdata;

  assign unused_wdata = ^{mem_wdata_i[31:12], mem_wdata_i[7:4]};

  // Two-flop synchronizer for the raw asynchronous buttons
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    deb_d = deb_q;
    rise  = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
          rise[i]  = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef BTN_REPEAT_EN
  localparam logic [24:0] HOLD_LAST   = 25'(REPEAT_DELAY - 1);
  localparam logic [24:0] HOLD_RELOAD = 25'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [24:0] hold_q [4];
  logic [24:0] hold_d [4];

  // Hold timer: first repeat after REPEAT_DELAY, then every REPEAT_PERIOD cycles
  always_comb begin
    inject = '0;
    for (int i = 0; i < 4; i++) begin
      hold_d[i] = '0;
      if (deb_q[i]) begin
        if (hold_q[i] == HOLD_LAST) begin
          inject[i] = 1'b1;
          hold_d[i] = HOLD_RELOAD;
        end else begin
          hold_d[i] = hold_q[i] + 25'd1;
        end
      end
    end
  end

  // Hold timer registers
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 4; i++) hold_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) hold_q[i] <= hold_d[i];
    end
  end
`else
  assign inject = '0;
`endif

  assign evt     = rise | inject;
  assign clr_hit = mem_wren_i && (mem_addr_i == CLR_ADDR);
  assign clr_ev  = {4{clr_hit}} & mem_wdata_i[3:0];
  assign clr_ovf = {4{clr_hit}} & mem_wdata_i[11:8];

  // A new event beats a same-cycle clear; overflow only when an unconsumed event is hit again
  always_comb begin
    ev_d  = evt | (ev_q & ~clr_ev);
    ovf_d = (evt & ev_q & ~clr_ev) | (ovf_q & ~clr_ovf);
  end

  // Debounce and event state registers
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      deb_q <= '0;
      ev_q  <= '0;
      ovf_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      deb_q <= deb_d;
      ev_q  <= ev_d;
      ovf_q <= ovf_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign hit_o   = (mem_addr_i == STAT_ADDR);
  assign rdata_o = hit_o ? {20'b0, ovf_q, deb_q, ev_q} : 32'b0;

endmodule

// File: tb/tb_mmio_button_port.sv
// Bench for mmio_button_port: behavioural model plus directed and random stimulus.
module tb_mmio_button_port;
  localparam int DC   = 4;
  localparam int RD   = 10;
  localparam int RP   = 5;
  localparam logic [31:0] STAT = 32'd4098;
  localparam logic [31:0] CLR  = 32'd4099;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  btn = '0;
  logic [31:0] addr = STAT;
  logic        wren = 1'b0;
  logic [31:0] wdata = '0;
  logic        hit;
  logic [31:0] rdata;

  mmio_button_port #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(20),
    .STAT_ADDR(STAT),
    .CLR_ADDR(CLR)
`ifdef BTN_REPEAT_EN
    ,
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
`endif
  ) dut (
    .clock_i(clk),
    .reset_n_i(rst_n),
    .btn_i(btn),
    .mem_addr_i(addr),
    .mem_wren_i(wren),
    .mem_wdata_i(wdata),
    .hit_o(hit),
    .rdata_o(rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: raw samples delayed two edges, a level is accepted once the
  // last DC samples all disagree with it, events/overflow from the register rules.
  logic [3:0] raw_m [2];
  logic [3:0] win_m [DC];
  logic [3:0] d_m, ev_m, ovf_m;
  int         held_m [4];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        raw_m[0] = '0; raw_m[1] = '0;
        for (int k = 0; k < DC; k++) win_m[k] = '0;
        d_m = '0; ev_m = '0; ovf_m = '0;
        for (int i = 0; i < 4; i++) held_m[i] = 0;
      end else begin
        logic [3:0] s, flip, rise, inj;
        logic       clr;
        s = raw_m[1];
        raw_m[1] = raw_m[0];
        raw_m[0] = btn;
        for (int k = DC - 1; k > 0; k--) win_m[k] = win_m[k-1];
        win_m[0] = s;
        clr = wren && (addr == CLR);
        for (int i = 0; i < 4; i++) begin
          flip[i] = 1'b1;
          for (int k = 0; k < DC; k++) if (win_m[k][i] == d_m[i]) flip[i] = 1'b0;
          rise[i] = flip[i] && !d_m[i];
          inj[i]  = 1'b0;
          if (d_m[i]) held_m[i] = held_m[i] + 1;
          else held_m[i] = 0;
`ifdef BTN_REPEAT_EN
          if (d_m[i] && held_m[i] >= RD && ((held_m[i] - RD) % RP) == 0) inj[i] = 1'b1;
`endif
          if (rise[i]) held_m[i] = 0;
          if (rise[i] || inj[i]) begin
            if (ev_m[i] && !(clr && wdata[i])) ovf_m[i] = 1'b1;
            else if (clr && wdata[8+i]) ovf_m[i] = 1'b0;
            ev_m[i] = 1'b1;
          end else begin
            if (clr && wdata[i]) ev_m[i] = 1'b0;
            if (clr && wdata[8+i]) ovf_m[i] = 1'b0;
          end
          if (flip[i]) d_m[i] = ~d_m[i];
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      check("hit", {31'b0, hit}, {31'b0, addr == STAT});
      check("rdata", rdata, (addr == STAT) ? {20'b0, ovf_m, d_m, ev_m} : 32'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic lit(input string name, input logic [31:0] exp);
    #1;
    check(name, rdata, exp);
  endtask

  task automatic store(input logic [31:0] v);
    addr = CLR; wren = 1'b1; wdata = v;
    tick();
    addr = STAT; wren = 1'b0; wdata = '0;
  endtask

  int seen[$];
`ifdef BTN_REPEAT_EN
  int exp_ev[$] = '{10, 15, 20, 25};
`else
  int exp_ev[$] = '{};
`endif

  initial begin
    int rem [4];
    logic pend;

    // Reset and first press
    ticks(3);
    lit("reset_held", 32'h0);
    rst_n = 1'b1;
    btn = 4'b0001;
    ticks(6);
    lit("first_rise", 32'h011);
    ticks(2);
    btn = 4'b0011;
    ticks(3);
    rst_n = 1'b0;
    lit("async_reset", 32'h0);
    btn = 4'b0001;
    ticks(2);
    lit("reset_hold2", 32'h0);
    rst_n = 1'b1;
    ticks(5);
    lit("post_reset_5", 32'h0);
    tick();
    lit("post_reset_6", 32'h011);
    btn = 4'b0000;
    ticks(8);
    store(32'hF0F);
    lit("cleared", 32'h0);

    // Short glitch never accepted
    btn = 4'b0100;
    ticks(3);
    btn = 4'b0000;
    ticks(8);
    lit("glitch", 32'h0);

    // Press and release latency
    btn = 4'b0010;
    ticks(5);
    lit("btn1_5", 32'h0);
    tick();
    lit("btn1_press", 32'h022);
    btn = 4'b0000;
    ticks(5);
    lit("btn1_hold", 32'h022);
    tick();
    lit("btn1_release", 32'h002);
    store(32'h2);
    lit("btn1_clr", 32'h0);

    // Overflow and partial clears
    for (int n = 0; n < 2; n++) begin
      btn = 4'b1000; ticks(8);
      btn = 4'b0000; ticks(8);
    end
    lit("btn3_ovf", 32'h808);
    store(32'h800);
    lit("btn3_clr_ovf", 32'h008);
    store(32'h008);
    lit("btn3_clr_ev", 32'h0);

    // Clear coinciding with a rise
    btn = 4'b0001;
    ticks(5);
    store(32'h1);
    lit("clr_vs_rise", 32'h011);
    btn = 4'b0000;
    ticks(8);
    lit("ev0_kept", 32'h001);
    btn = 4'b0001;
    ticks(5);
    store(32'h1);
    lit("clr_vs_rise_ovf", 32'h011);
    btn = 4'b0000;
    ticks(8);
    store(32'hF0F);
    lit("cleared2", 32'h0);

    // Hold button 0 and watch for repeat events
    btn = 4'b0001;
    ticks(6);
    lit("rep_rise", 32'h011);
    pend = 1'b1;
    for (int k = 1; k < 30; k++) begin
      if (pend) begin
        store(32'h1);
      end else begin
        tick();
      end
      #1;
      pend = rdata[0];
      if (rdata[0]) seen.push_back(k);
    end
    check("rep_count", 32'(seen.size()), 32'(exp_ev.size()));
    for (int j = 0; j < seen.size() && j < exp_ev.size(); j++)
      check("rep_offset", 32'(seen[j]), 32'(exp_ev[j]));
    btn = 4'b0000;
    ticks(10);
    store(32'hF0F);
    lit("cleared3", 32'h0);

    // Random traffic
    for (int i = 0; i < 4; i++) rem[i] = $urandom_range(1, 20);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (rem[i] == 0) begin
          btn[i] = ~btn[i];
          rem[i] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(1, 30);
        end else begin
          rem[i] = rem[i] - 1;
        end
      end
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: addr = STAT;
        6, 7:             addr = CLR;
        8:                addr = 32'd4097;
        default:          addr = $urandom;
      endcase
      wren  = ($urandom_range(0, 3) == 0);
      wdata = $urandom;
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      tick();
    end
    rst_n = 1'b1;
    wren = 1'b0;
    addr = STAT;
    ticks(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
